seg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for a multi-digit common-anode 7-segment display. Holds a DIGITS-wide packed BCD word and steps one shared BCD-to-segment decoder (4-bit code in, active-low a–g out, codes >9 blank) across the digits. It drives the digit-select lines, inserts a dead-time gap between digits to suppress ghosting, and accepts new display values through a ready/valid write port. New values are committed only at frame boundaries, so a frame never shows a mix of old and new digits.

---
 rtl/seg_scan_pkg.sv | 48 ++++
 rtl/seg_lzb.sv | 27 ++
 rtl/seg_scan_ctrl.sv | 136 +++++++++++++
 tb/tb_seg_scan_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the 7-segment scan controller and its decoder.
package seg_scan_pkg;

    typedef enum logic [0:0] {
        ST_GAP  = 1'b0,
        ST_SCAN = 1'b1
    } scan_state_e;

    localparam logic [3:0] BLANK_CODE = 4'hF;

    // Active-low segments, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0   = 7'b100_0000;
    localparam logic [6:0] SEG_1   = 7'b111_1001;
    localparam logic [6:0] SEG_2   = 7'b010_0100;
    localparam logic [6:0] SEG_3   = 7'b011_0000;
    localparam logic [6:0] SEG_4   = 7'b001_1001;
    localparam logic [6:0] SEG_5   = 7'b001_0010;
    localparam logic [6:0] SEG_6   = 7'b000_0010;
    localparam logic [6:0] SEG_7   = 7'b111_1000;
    localparam logic [6:0] SEG_8   = 7'b000_0000;
    localparam logic [6:0] SEG_9   = 7'b001_0000;
    localparam logic [6:0] SEG_OFF = 7'b111_1111;

    // Reference decode matching the external shared decoder; codes above 9 blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] code);
        case (code)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_OFF;
        endcase
    endfunction

    // Counter width covering the longer of the two phase lengths, never zero.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/seg_lzb.sv
// Combinational leading-zero blanker: zero digits above the most significant
// non-zero digit become BLANK_CODE; digit 0 is never blanked.
module seg_lzb
    import seg_scan_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) (
    input  logic [4*DIGITS-1:0] active_i,
    output logic [4*DIGITS-1:0] blanked_o
);

    logic all_zero_above;

    always_comb begin
        blanked_o      = active_i;
        all_zero_above = 1'b1;
        for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
            if (active_i[4*i +: 4] != 4'h0) begin
                all_zero_above = 1'b0;
            end
            if (all_zero_above) begin
                blanked_o[4*i +: 4] = BLANK_CODE;
            end
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with frame-aligned value commit.
// Optional build macro: LEADING_ZERO_BLANK_EN (blank leading zero digits).
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned SCAN_DIV = 50000,
    parameter int unsigned DEAD_CYC = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en_i,
    input  logic [4*DIGITS-1:0]   wr_data_i,
    output logic                  wr_ready_o,
    output logic [3:0]            bcd_out_o,
    output logic [DIGITS-1:0]     dig_sel_n_o,
    output logic                  frame_done_o
);

    localparam int unsigned DATA_W = 4 * DIGITS;
    localparam int unsigned CNT_W  = cnt_width(SCAN_DIV, DEAD_CYC);
    localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

    scan_state_e                 state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [DATA_W-1:0]           active_q, active_d;
    logic [DATA_W-1:0]           shadow_q, shadow_d;
    logic                        ready_q, ready_d;
    logic                        frame_done_q, frame_done_d;
    logic [DIGITS-1:0]           dig_sel_q, dig_sel_d;
    logic [3:0]                  bcd_q, bcd_d;
    logic [DIGITS-1:0][3:0]      disp_word;

    // State register; outputs are registered from next-state so they track state with no lag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_GAP;
            cnt_q        <= '0;
            idx_q        <= '0;
            active_q     <= '0;
            shadow_q     <= '0;
            ready_q      <= 1'b1;
            frame_done_q <= 1'b0;
            dig_sel_q    <= '1;
            bcd_q        <= BLANK_CODE;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            active_q     <= active_d;
            shadow_q     <= shadow_d;
            ready_q      <= ready_d;
            frame_done_q <= frame_done_d;
            dig_sel_q    <= dig_sel_d;
            bcd_q        <= bcd_d;
        end
    end

    // Next-state: phase sequencing, digit stepping, write capture and frame commit
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + 1'b1;
        idx_d        = idx_q;
        active_d     = active_q;
        shadow_d     = shadow_q;
        ready_d      = ready_q;
        frame_done_d = 1'b0;

        case (state_q)
            ST_GAP: begin
                if (cnt_q == DEAD_LAST) begin
                    state_d = ST_SCAN;
                    cnt_d   = '0;
                end
            end
            ST_SCAN: begin
                if (cnt_q == SCAN_LAST) begin
                    state_d = ST_GAP;
                    cnt_d   = '0;
                    if (idx_q == IDX_LAST) begin
                        idx_d        = '0;
                        frame_done_d = 1'b1;
                        // Only a write pending before this cycle is committed
                        if (!ready_q) begin
                            active_d = shadow_q;
                            ready_d  = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_GAP;
                cnt_d   = '0;
            end
        endcase

        if (wr_en_i && ready_q) begin
            shadow_d = wr_data_i;
            ready_d  = 1'b0;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    seg_lzb #(
        .DIGITS (DIGITS)
    ) u_lzb (
        .active_i  (active_d),
        .blanked_o (disp_word)
    );
`else
    assign disp_word = active_d;
`endif

    // Output decode of the upcoming state
    always_comb begin
        dig_sel_d = '1;
        bcd_d     = BLANK_CODE;
        if (state_d == ST_SCAN) begin
            dig_sel_d = ~(DIGITS'(1) << idx_d);
            bcd_d     = disp_word[idx_d];
        end
    end

    assign wr_ready_o   = ready_q;
    assign frame_done_o = frame_done_q;
    assign dig_sel_n_o  = dig_sel_q;
    assign bcd_out_o    = bcd_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed self-checking bench for seg_scan_ctrl (DIGITS=4, SCAN_DIV=4, DEAD_CYC=2).
// Expected values follow LEADING_ZERO_BLANK_EN when the macro is defined.
module tb_seg_scan_ctrl;

    localparam int unsigned DIGITS   = 4;
    localparam int unsigned SCAN_DIV = 4;
    localparam int unsigned DEAD_CYC = 2;
    localparam int          SLOT     = 6;
    localparam int          FRAME    = 24;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        wr_ready;
    logic [3:0]  bcd_out;
    logic [3:0]  dig_sel_n;
    logic        frame_done;

    int vectors;
    int miscompares;

    seg_scan_ctrl #(
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV),
        .DEAD_CYC (DEAD_CYC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en_i      (wr_en),
        .wr_data_i    (wr_data),
        .wr_ready_o   (wr_ready),
        .bcd_out_o    (bcd_out),
        .dig_sel_n_o  (dig_sel_n),
        .frame_done_o (frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected code for digit d of a committed word.
    function automatic logic [3:0] exp_digit(input logic [15:0] word, input int d);
        logic [15:0] w;
        logic [3:0]  code;
        w    = word >> (4 * d);
        code = w[3:0];
`ifdef LEADING_ZERO_BLANK_EN
        if (d >= 1 && w == 16'h0000) code = 4'hF;
`endif
        return code;
    endfunction

    // Cycle c counts posedges since reset release.
    function automatic logic [3:0] exp_sel(input int c);
        int pos;
        pos = c % FRAME;
        if ((pos % SLOT) < DEAD_CYC) return 4'b1111;
        return ~(4'b0001 << (pos / SLOT));
    endfunction

    function automatic logic [3:0] exp_bcd(input int c, input logic [15:0] word);
        int pos;
        pos = c % FRAME;
        if ((pos % SLOT) < DEAD_CYC) return 4'hF;
        return exp_digit(word, pos / SLOT);
    endfunction

    function automatic logic exp_fd(input int c);
        return (c > 0) && ((c % FRAME) == 0);
    endfunction

    // Reset is released on a negedge; the caller is then at cycle 0.
    task automatic apply_reset();
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_data = 16'h0000;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        wr_data = 16'h0000;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (dig_sel_n !== 4'b1111) begin
            miscompares++;
            $display("FAIL reset_sel got=%b exp=1111", dig_sel_n);
        end
        vectors++;
        if (bcd_out !== 4'hF) begin
            miscompares++;
            $display("FAIL reset_bcd got=%h exp=f", bcd_out);
        end
        vectors++;
        if (wr_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready got=%b exp=1", wr_ready);
        end
        vectors++;
        if (frame_done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_frame_done got=%b exp=0", frame_done);
        end
    endtask

    task automatic test_scan_sequence();
        apply_reset();
        for (int c = 0; c < 30; c++) begin
            if (c > 0) @(negedge clk);
            vectors++;
            if (dig_sel_n !== exp_sel(c) || bcd_out !== exp_bcd(c, 16'h0000) ||
                frame_done !== exp_fd(c) || wr_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL scan_seq cyc=%0d got sel=%b bcd=%h fd=%b rdy=%b exp sel=%b bcd=%h fd=%b rdy=1",
                         c, dig_sel_n, bcd_out, frame_done, wr_ready,
                         exp_sel(c), exp_bcd(c, 16'h0000), exp_fd(c));
            end
        end
    endtask

    // Write at cycle 3, second write at cycle 10 must be ignored.
    task automatic test_write_commit();
        logic [15:0] word;
        logic        rdy;
        apply_reset();
        for (int c = 0; c < 2 * FRAME; c++) begin
            if (c > 0) @(negedge clk);
            word = (c < FRAME) ? 16'h0000 : 16'h1234;
            rdy  = !(c >= 4 && c < FRAME);
            vectors++;
            if (dig_sel_n !== exp_sel(c) || bcd_out !== exp_bcd(c, word) ||
                frame_done !== exp_fd(c) || wr_ready !== rdy) begin
                miscompares++;
                $display("FAIL write_commit cyc=%0d got sel=%b bcd=%h fd=%b rdy=%b exp sel=%b bcd=%h fd=%b rdy=%b",
                         c, dig_sel_n, bcd_out, frame_done, wr_ready,
                         exp_sel(c), exp_bcd(c, word), exp_fd(c), rdy);
            end
            wr_en   = (c == 3) || (c == 10);
            wr_data = (c == 10) ? 16'h5678 : 16'h1234;
        end
        wr_en = 1'b0;
    endtask

    // Write accepted on the commit cycle waits a whole extra frame.
    task automatic test_commit_edge_write();
        logic [15:0] word;
        logic        rdy;
        apply_reset();
        for (int c = 0; c < 3 * FRAME; c++) begin
            if (c > 0) @(negedge clk);
            word = (c < 2 * FRAME) ? 16'h0000 : 16'h1234;
            rdy  = !(c >= FRAME && c < 2 * FRAME);
            vectors++;
            if (dig_sel_n !== exp_sel(c) || bcd_out !== exp_bcd(c, word) ||
                frame_done !== exp_fd(c) || wr_ready !== rdy) begin
                miscompares++;
                $display("FAIL edge_write cyc=%0d got sel=%b bcd=%h fd=%b rdy=%b exp sel=%b bcd=%h fd=%b rdy=%b",
                         c, dig_sel_n, bcd_out, frame_done, wr_ready,
                         exp_sel(c), exp_bcd(c, word), exp_fd(c), rdy);
            end
            wr_en   = (c == FRAME - 1);
            wr_data = 16'h1234;
        end
        wr_en = 1'b0;
    endtask

    // Asynchronous reset during idx2 scan with a write pending.
    task automatic test_reset_mid();
        apply_reset();
        for (int c = 0; c < 15; c++) begin
            if (c > 0) @(negedge clk);
            wr_en   = (c == 3);
            wr_data = 16'h1234;
        end
        wr_en = 1'b0;
        @(negedge clk);
        vectors++;
        if (dig_sel_n !== 4'b1011) begin
            miscompares++;
            $display("FAIL mid_pre_sel got=%b exp=1011", dig_sel_n);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if (dig_sel_n !== 4'b1111 || bcd_out !== 4'hF || wr_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_reset got sel=%b bcd=%h rdy=%b exp sel=1111 bcd=f rdy=1",
                     dig_sel_n, bcd_out, wr_ready);
        end
        apply_reset();
        for (int c = 0; c < 2 * FRAME; c++) begin
            if (c > 0) @(negedge clk);
            vectors++;
            if (dig_sel_n !== exp_sel(c) || bcd_out !== exp_bcd(c, 16'h0000) ||
                frame_done !== exp_fd(c) || wr_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL mid_restart cyc=%0d got sel=%b bcd=%h fd=%b rdy=%b exp sel=%b bcd=%h fd=%b rdy=1",
                         c, dig_sel_n, bcd_out, frame_done, wr_ready,
                         exp_sel(c), exp_bcd(c, 16'h0000), exp_fd(c));
            end
        end
    endtask

    task automatic test_blanking();
        logic [15:0] words [3];
        logic [15:0] word;
        logic        rdy;
        words[0] = 16'h0050;
        words[1] = 16'h0000;
        words[2] = 16'h00A0;
        for (int k = 0; k < 3; k++) begin
            apply_reset();
            for (int c = 0; c < 2 * FRAME; c++) begin
                if (c > 0) @(negedge clk);
                word = (c < FRAME) ? 16'h0000 : words[k];
                rdy  = !(c >= 1 && c < FRAME);
                vectors++;
                if (dig_sel_n !== exp_sel(c) || bcd_out !== exp_bcd(c, word) ||
                    frame_done !== exp_fd(c) || wr_ready !== rdy) begin
                    miscompares++;
                    $display("FAIL blank_%h cyc=%0d got sel=%b bcd=%h fd=%b rdy=%b exp sel=%b bcd=%h fd=%b rdy=%b",
                             words[k], c, dig_sel_n, bcd_out, frame_done, wr_ready,
                             exp_sel(c), exp_bcd(c, word), exp_fd(c), rdy);
                end
                wr_en   = (c == 0);
                wr_data = words[k];
            end
            wr_en = 1'b0;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        wr_en       = 1'b0;
        wr_data     = 16'h0000;
        test_reset();
        test_scan_sequence();
        test_write_commit();
        test_commit_edge_write();
        test_reset_mid();
        test_blanking();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
